// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit ALU datapath.
// Holds PC, IR, an 8x8 register file and the compare flags; talks to imem/dmem via req/ack.
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    output logic [7:0]  dmem_wdata,
    input  logic [7:0]  dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  alu_opcode,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    input  logic [7:0]  alu_result,
    input  logic [2:0]  alu_flags,
    output logic [7:0]  pc,
    output logic        halted
);

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_LOADC = 5'd3,
        OP_LOAD  = 5'd4,
        OP_STORE = 5'd5,
        OP_CMP   = 5'd6,
        OP_JMP   = 5'd7,
        OP_JZ    = 5'd8,
        OP_JC    = 5'd9,
        OP_HALT  = 5'd10
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_e;

    state_e      r_state, w_state_nxt;
    logic        r_run;
    logic [7:0]  r_pc, w_pc_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic [7:0]  r_opa, w_opa_nxt;
    logic [7:0]  r_opb, w_opb_nxt;
    logic [2:0]  r_flags;
    logic [7:0]  r_regs [8];

    logic        w_rf_we;
    logic [7:0]  w_rf_wdata;
    logic        w_flags_we;

    logic [4:0]  w_opc;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [7:0]  w_imm;

    assign w_opc     = r_ir[15:11];
    assign w_rd      = r_ir[10:8];
    assign w_rs      = r_ir[7:5];
    assign w_imm     = r_ir[7:0];
    assign pc        = r_pc;
    assign imem_addr = r_pc;

    // r_run stays low for the first clock after reset so imem_req rises on that edge, not before
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_flags <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            if (w_flags_we) begin
                r_flags <= alu_flags;
            end
            if (w_rf_we) begin
                r_regs[w_rd] <= w_rf_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_rf_we     = 1'b0;
        w_rf_wdata  = '0;
        w_flags_we  = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        alu_opcode  = OP_NOP;
        alu_op1     = '0;
        alu_op2     = '0;
        halted      = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = r_run;
                if (r_run && imem_ack) begin
                    w_ir_nxt    = imem_data;
                    w_pc_nxt    = r_pc + 8'd1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_opa_nxt   = r_regs[w_rd];
                w_opb_nxt   = r_regs[w_rs];
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                case (w_opc)
                    OP_ADD, OP_SUB: begin
                        alu_opcode = w_opc;
                        alu_op1    = r_opa;
                        alu_op2    = r_opb;
                        w_rf_we    = 1'b1;
                        w_rf_wdata = alu_result;
                    end
                    OP_LOADC: begin
                        alu_opcode = w_opc;
                        alu_op2    = w_imm;
                        w_rf_we    = 1'b1;
                        w_rf_wdata = alu_result;
                    end
                    OP_CMP: begin
                        alu_opcode = w_opc;
                        alu_op1    = r_opa;
                        alu_op2    = r_opb;
                        w_flags_we = 1'b1;
                    end
                    OP_JMP: w_pc_nxt = w_imm;
                    OP_JZ: begin
                        if (r_flags[0]) begin
                            w_pc_nxt = w_imm;
                        end
                    end
                    OP_JC: begin
                        if (r_flags[1]) begin
                            w_pc_nxt = w_imm;
                        end
                    end
                    OP_LOAD, OP_STORE: w_state_nxt = S_MEM;
                    OP_HALT:           w_state_nxt = S_HALTED;
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (w_opc == OP_STORE);
                dmem_addr  = w_imm;
                dmem_wdata = r_opa;
                if (dmem_ack) begin
                    if (w_opc == OP_LOAD) begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = dmem_rdata;
                    end
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALTED: halted = 1'b1;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

endmodule
